// File: rtl/clock_set_ctrl.sv
// Time-setting front end for the 24h clock: debounced MODE/UP keys walk an
// hour/minute/second edit FSM that presets the BCD counters and blinks the edited field.
`timescale 1ns/1ps
module clock_set_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_MODE,
    input  logic       KEY_UP,
    input  logic [3:0] CUR_QLsec,
    input  logic [2:0] CUR_QHsec,
    input  logic [3:0] CUR_QLmin,
    input  logic [2:0] CUR_QHmin,
    input  logic [3:0] CUR_QLhour,
    input  logic [1:0] CUR_QHhour,
    output logic [3:0] SET_QLsec,
    output logic [2:0] SET_QHsec,
    output logic [3:0] SET_QLmin,
    output logic [2:0] SET_QHmin,
    output logic [3:0] SET_QLhour,
    output logic [1:0] SET_QHhour,
    output logic       LOAD,
    output logic       RUN,
    output logic [5:0] BLANK
);

    localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned BCW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {RUN_ST, ED_HOUR, ED_MIN, ED_SEC, COMMIT} state_t;

    logic [1:0]     key_raw;
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     acc;
    logic [1:0]     press;
    logic [DCW-1:0] deb_cnt [2];
    logic           mode_evt;
    logic           up_evt;

    state_t         state;
    logic [BCW-1:0] blink_cnt;
    logic           blink_ph;
    logic [5:0]     edit_mask;
    logic           hr_wrap;
    logic           mn_wrap;
    logic           sc_wrap;

    assign key_raw = {KEY_UP, KEY_MODE};

    // Synchronise, debounce, and emit a single-cycle event on each accepted press
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            press <= '0;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= '0;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == acc[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DCW'(DEB_CYCLES - 1)) begin
                    deb_cnt[k] <= '0;
                    acc[k]     <= sync2[k];
                    press[k]   <= sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DCW'(1);
                end
            end
        end
    end

    // MODE takes priority over a coincident UP
    assign mode_evt = press[0];
    assign up_evt   = press[1] & ~press[0];

    // Values at or beyond the field maximum (including bad snapshots) wrap to 00
    assign hr_wrap = (SET_QHhour > 2'd2) || ((SET_QHhour == 2'd2) && (SET_QLhour >= 4'd3));
    assign mn_wrap = (SET_QHmin  > 3'd5) || ((SET_QHmin  == 3'd5) && (SET_QLmin  >= 4'd9));
    assign sc_wrap = (SET_QHsec  > 3'd5) || ((SET_QHsec  == 3'd5) && (SET_QLsec  >= 4'd9));

    always_comb begin
        edit_mask = 6'b000000;
        case (state)
            ED_HOUR: edit_mask = 6'b110000;
            ED_MIN:  edit_mask = 6'b001100;
            ED_SEC:  edit_mask = 6'b000011;
            default: edit_mask = 6'b000000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN_ST;
            SET_QLsec  <= '0;
            SET_QHsec  <= '0;
            SET_QLmin  <= '0;
            SET_QHmin  <= '0;
            SET_QLhour <= '0;
            SET_QHhour <= '0;
            LOAD       <= 1'b0;
            RUN        <= 1'b1;
            BLANK      <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
        end else begin
            LOAD <= 1'b0;
            case (state)
                RUN_ST: begin
                    if (mode_evt) begin
                        state      <= ED_HOUR;
                        RUN        <= 1'b0;
                        SET_QLsec  <= CUR_QLsec;
                        SET_QHsec  <= CUR_QHsec;
                        SET_QLmin  <= CUR_QLmin;
                        SET_QHmin  <= CUR_QHmin;
                        SET_QLhour <= CUR_QLhour;
                        SET_QHhour <= CUR_QHhour;
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        BLANK      <= '0;
                    end
                end
                ED_HOUR, ED_MIN, ED_SEC: begin
                    // Any key event restarts the blink with the digits shown
                    if (mode_evt || up_evt) begin
                        blink_cnt <= '0;
                        blink_ph  <= 1'b0;
                        BLANK     <= '0;
                    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                        blink_cnt <= '0;
                        blink_ph  <= ~blink_ph;
                        BLANK     <= blink_ph ? 6'b000000 : edit_mask;
                    end else begin
                        blink_cnt <= blink_cnt + BCW'(1);
                    end

                    if (mode_evt) begin
                        case (state)
                            ED_HOUR: state <= ED_MIN;
                            ED_MIN:  state <= ED_SEC;
                            default: begin
                                state <= COMMIT;
                                LOAD  <= 1'b1;
                            end
                        endcase
                    end else if (up_evt) begin
                        case (state)
                            ED_HOUR: begin
                                if (hr_wrap) begin
                                    SET_QHhour <= '0;
                                    SET_QLhour <= '0;
                                end else if (SET_QLhour >= 4'd9) begin
                                    SET_QHhour <= SET_QHhour + 2'd1;
                                    SET_QLhour <= '0;
                                end else begin
                                    SET_QLhour <= SET_QLhour + 4'd1;
                                end
                            end
                            ED_MIN: begin
                                if (mn_wrap) begin
                                    SET_QHmin <= '0;
                                    SET_QLmin <= '0;
                                end else if (SET_QLmin >= 4'd9) begin
                                    SET_QHmin <= SET_QHmin + 3'd1;
                                    SET_QLmin <= '0;
                                end else begin
                                    SET_QLmin <= SET_QLmin + 4'd1;
                                end
                            end
                            default: begin
                                if (sc_wrap) begin
                                    SET_QHsec <= '0;
                                    SET_QLsec <= '0;
                                end else if (SET_QLsec >= 4'd9) begin
                                    SET_QHsec <= SET_QHsec + 3'd1;
                                    SET_QLsec <= '0;
                                end else begin
                                    SET_QLsec <= SET_QLsec + 4'd1;
                                end
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    state <= RUN_ST;
                    RUN   <= 1'b1;
                end
                default: begin
                    state <= RUN_ST;
                    RUN   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: random key traffic feeds a time-setting
// model that queues expected output changes; a monitor matches them as they appear.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned BDIV = 8;
    localparam int          LAT  = int'(DEB) + 3;

    logic       clk = 1'b0;
    logic       RST;
    logic       KEY_MODE;
    logic       KEY_UP;
    logic [3:0] CUR_QLsec;
    logic [2:0] CUR_QHsec;
    logic [3:0] CUR_QLmin;
    logic [2:0] CUR_QHmin;
    logic [3:0] CUR_QLhour;
    logic [1:0] CUR_QHhour;
    logic [3:0] SET_QLsec;
    logic [2:0] SET_QHsec;
    logic [3:0] SET_QLmin;
    logic [2:0] SET_QHmin;
    logic [3:0] SET_QLhour;
    logic [1:0] SET_QHhour;
    logic       LOAD;
    logic       RUN;
    logic [5:0] BLANK;

    always #5 clk = ~clk;

    clock_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_DIV(BDIV)) u_dut (
        .CLK(clk), .RST(RST), .KEY_MODE(KEY_MODE), .KEY_UP(KEY_UP),
        .CUR_QLsec(CUR_QLsec), .CUR_QHsec(CUR_QHsec),
        .CUR_QLmin(CUR_QLmin), .CUR_QHmin(CUR_QHmin),
        .CUR_QLhour(CUR_QLhour), .CUR_QHhour(CUR_QHhour),
        .SET_QLsec(SET_QLsec), .SET_QHsec(SET_QHsec),
        .SET_QLmin(SET_QLmin), .SET_QHmin(SET_QHmin),
        .SET_QLhour(SET_QLhour), .SET_QHhour(SET_QHhour),
        .LOAD(LOAD), .RUN(RUN), .BLANK(BLANK)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit run; bit load; int hr; int mn; int sc; } obs_t;
    typedef struct { int cyc; int field; } blk_t;

    obs_t sq[$];
    blk_t bq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;

    // Model: mode 0 = running, 1/2/3 = editing hour/min/sec
    int   m_mode, m_hr, m_mn, m_sc;
    obs_t last;

    function automatic int wrap_inc(int v, int top);
        return (v >= top) ? 0 : v + 1;
    endfunction

    function automatic logic [21:0] pack_obs(bit run, bit load, int hr, int mn, int sc);
        return {run, load, 2'(hr / 10), 4'(hr % 10), 3'(mn / 10), 4'(mn % 10),
                3'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [5:0] fmask(int f);
        case (f)
            1:       return 6'b110000;
            2:       return 6'b001100;
            3:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic push_obs(int c, bit run, bit load);
        obs_t e;
        e.cyc = c; e.run = run; e.load = load; e.hr = m_hr; e.mn = m_mn; e.sc = m_sc;
        if (e.run != last.run || e.load != last.load || e.hr != last.hr ||
            e.mn != last.mn || e.sc != last.sc)
            sq.push_back(e);
        last = e;
    endtask

    task automatic push_blk(int c, int f);
        blk_t b;
        b.cyc = c; b.field = f;
        bq.push_back(b);
    endtask

    task automatic model_mode(int c);
        case (m_mode)
            0: begin
                m_hr = int'(CUR_QHhour) * 10 + int'(CUR_QLhour);
                m_mn = int'(CUR_QHmin) * 10 + int'(CUR_QLmin);
                m_sc = int'(CUR_QHsec) * 10 + int'(CUR_QLsec);
                m_mode = 1;
                push_obs(c, 1'b0, 1'b0);
                push_blk(c, 1);
            end
            1, 2: begin
                m_mode = m_mode + 1;
                push_blk(c, m_mode);
            end
            default: begin
                m_mode = 0;
                push_obs(c, 1'b0, 1'b1);
                push_obs(c + 1, 1'b1, 1'b0);
                push_blk(c, 0);
            end
        endcase
    endtask

    task automatic model_up(int c);
        if (m_mode == 0) return;
        case (m_mode)
            1:       m_hr = wrap_inc(m_hr, 23);
            2:       m_mn = wrap_inc(m_mn, 59);
            default: m_sc = wrap_inc(m_sc, 59);
        endcase
        push_obs(c, 1'b0, 1'b0);
        push_blk(c, m_mode);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(bit m, bit u, int hold);
        int c;
        c = cyc + LAT;
        KEY_MODE = m;
        KEY_UP   = u;
        if (m) model_mode(c);
        else if (u) model_up(c);
        tick(hold);
        KEY_MODE = 1'b0;
        KEY_UP   = 1'b0;
        tick(8 + int'($urandom_range(0, 22)));
    endtask

    task automatic glitch(int g);
        KEY_UP = 1'b1;
        tick(g);
        KEY_UP = 1'b0;
        tick(9);
    endtask

    task automatic do_reset();
        int c;
        c = cyc + 1;
        RST = 1'b1;
        m_mode = 0; m_hr = 0; m_mn = 0; m_sc = 0;
        push_obs(c, 1'b1, 1'b0);
        push_blk(c, 0);
        tick(2);
        RST = 1'b0;
        tick(3);
    endtask

    task automatic set_cur(int hr, int mn, int sc);
        CUR_QHhour = 2'(hr / 10); CUR_QLhour = 4'(hr % 10);
        CUR_QHmin  = 3'(mn / 10); CUR_QLmin  = 4'(mn % 10);
        CUR_QHsec  = 3'(sc / 10); CUR_QLsec  = 4'(sc % 10);
    endtask

    // Monitor: matches every change of RUN/LOAD/SET against the queue and checks BLANK each cycle
    always @(negedge clk) begin : mon
        logic [21:0] o;
        logic [21:0] x;
        logic [21:0] prev;
        logic [5:0]  xb;
        obs_t        e;
        bit          started;
        bit          fin_seen;
        int          b_field;
        int          b_org;

        while (bq.size() > 0 && bq[0].cyc <= cyc) begin
            b_field = bq[0].field;
            b_org   = bq[0].cyc;
            void'(bq.pop_front());
        end
        o = {RUN, LOAD, SET_QHhour, SET_QLhour, SET_QHmin, SET_QLmin, SET_QHsec, SET_QLsec};
        if (mon_en) begin
            if (!started) begin
                x = pack_obs(1'b1, 1'b0, 0, 0, 0);
                checks++;
                if (o !== x) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, o, x);
                end
                prev = o;
                started = 1'b1;
            end else if (o !== prev) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h exp=no change", cyc, o);
                end else begin
                    e = sq.pop_front();
                    x = pack_obs(e.run, e.load, e.hr, e.mn, e.sc);
                    if (o !== x || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL output_change cyc=%0d got=%h exp=%h at cyc %0d",
                                 cyc, o, x, e.cyc);
                    end
                end
                prev = o;
            end

            xb = (b_field == 0 || (((cyc - b_org) / int'(BDIV)) % 2) == 0) ? 6'b0 : fmask(b_field);
            checks++;
            if (BLANK !== xb) begin
                errors++;
                $display("FAIL blank cyc=%0d got=%b exp=%b", cyc, BLANK, xb);
            end

            if (done && !fin_seen) begin
                checks++;
                if (sq.size() != 0) begin
                    errors++;
                    $display("FAIL missing_changes got=%0d pending exp=0 next at cyc %0d",
                             sq.size(), sq[0].cyc);
                end
                fin_seen = 1'b1;
            end
        end
    end

    initial begin
        int r;
        RST = 1'b1; KEY_MODE = 1'b0; KEY_UP = 1'b0;
        set_cur(0, 0, 0);
        tick(2);
        RST = 1'b0;
        tick(1);
        m_mode = 0; m_hr = 0; m_mn = 0; m_sc = 0;
        last.cyc = 0; last.run = 1'b1; last.load = 1'b0; last.hr = 0; last.mn = 0; last.sc = 0;
        mon_en = 1'b1;
        tick(2);

        // Snapshot, then reset mid-edit with no LOAD
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b0, 6);
        do_reset();

        // Wrap cases, glitch rejection, MODE+UP priority, commit
        set_cur(23, 59, 9);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 6);
        glitch(3);
        press(1'b1, 1'b1, 6);
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);

        // Long hold yields a single increment
        set_cur(19, 9, 58);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 40);
        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b0, 5);

        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_cur(int'($urandom_range(0, 3)) * 10 + int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 7)) * 10 + int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 7)) * 10 + int'($urandom_range(0, 9)));
            r = int'($urandom_range(0, 99));
            if (r < 30)      press(1'b1, 1'b0, int'($urandom_range(4, 12)));
            else if (r < 65) press(1'b0, 1'b1, int'($urandom_range(4, 12)));
            else if (r < 75) press(1'b1, 1'b1, int'($urandom_range(4, 12)));
            else if (r < 87) glitch(int'($urandom_range(1, 3)));
            else if (r < 93) do_reset();
            else             press(1'b0, 1'b1, 40);
        end

        tick(20);
        done = 1'b1;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
